// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter driving the select input of the mux block.
// Picks one of 2**SEL_WIDTH sticky requesters, holds the choice under a
// valid/ready handshake and returns a one-cycle ack on each transfer.
// Optional macro RR_ARBITER_PRIO0_EN: requester 0 wins every arbitration it is
// eligible for, and transfers to it leave the round-robin pointer untouched.
module rr_arbiter #(
  parameter int SEL_WIDTH = 1,
  localparam int N = 2 ** SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 ready,
  output logic                 valid,
  output logic [SEL_WIDTH-1:0] sel,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         ack
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] ptr_nxt;
  logic [SEL_WIDTH-1:0] sel_nxt;
  logic [N-1:0]         gnt_nxt;
  logic                 valid_nxt;
  logic [N-1:0]         remaining;
  logic [SEL_WIDTH-1:0] winner;

  // Circular priority encoder: first set bit of r scanning upward from base
  // with wrap-around. With the priority option, bit 0 overrides the scan.
  function automatic logic [SEL_WIDTH-1:0] arb(input logic [N-1:0] r,
                                               input logic [SEL_WIDTH-1:0] base);
    logic [SEL_WIDTH-1:0] idx;
    logic                 found;
    arb   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = base + SEL_WIDTH'(i);
      if (!found && r[idx]) begin
        arb   = idx;
        found = 1'b1;
      end
    end
`ifdef RR_ARBITER_PRIO0_EN
    if (r[0]) begin
      arb = '0;
    end
`endif
  endfunction

  // Next-state logic: arbitrate from IDLE, hold while stalled, and on a
  // transfer advance the pointer and re-arbitrate among the other requesters.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    valid_nxt = valid;
    winner    = '0;
    remaining = req & ~gnt;
    case (state)
      IDLE: begin
        if (|req) begin
          winner          = arb(req, ptr);
          sel_nxt         = winner;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          valid_nxt       = 1'b1;
          state_nxt       = GRANT;
        end
      end
      GRANT: begin
        if (ready) begin
`ifdef RR_ARBITER_PRIO0_EN
          if (sel != '0) begin
            ptr_nxt = sel + SEL_WIDTH'(1);
          end
`else
          ptr_nxt = sel + SEL_WIDTH'(1);
`endif
          if (|remaining) begin
            winner          = arb(remaining, ptr_nxt);
            sel_nxt         = winner;
            gnt_nxt         = '0;
            gnt_nxt[winner] = 1'b1;
            valid_nxt       = 1'b1;
            state_nxt       = GRANT;
          end else begin
            sel_nxt   = '0;
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        sel_nxt   = '0;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; a synchronous reset drops any in-flight grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      valid <= valid_nxt;
    end
  end

  assign ack = gnt & {N{ready}};

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed scenarios plus sticky random requests for rr_arbiter
// with SEL_WIDTH=2, checked against a transaction-level reference model.
module tb_rr_arbiter;

  localparam int SW = 2;
  localparam int N  = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          ready;
  logic          valid;
  logic [SW-1:0] sel;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Reference model state: who holds the grant and where the scan starts.
  int m_valid     = 0;
  int m_sel       = 0;
  int m_ptr       = 0;
  int model_known = 0;
  int last_served = -1;

  rr_arbiter #(.SEL_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ready (ready),
    .valid (valid),
    .sel   (sel),
    .gnt   (gnt),
    .ack   (ack)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // First requester found walking ptr, ptr+1, ... modulo N.
  function automatic int ref_arb(input logic [N-1:0] r, input int p);
    int k;
`ifdef RR_ARBITER_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Advance the model by one rising edge using the inputs held at that edge.
  task automatic model_update();
    logic [N-1:0] rem;
    last_served = -1;
    if (!rst_n) begin
      m_valid     = 0;
      m_sel       = 0;
      m_ptr       = 0;
      model_known = 1;
    end else if (m_valid == 0) begin
      if (req != '0) begin
        m_sel   = ref_arb(req, m_ptr);
        m_valid = 1;
      end
    end else if (ready) begin
      last_served = m_sel;
`ifdef RR_ARBITER_PRIO0_EN
      if (m_sel != 0) m_ptr = (m_sel + 1) % N;
`else
      m_ptr = (m_sel + 1) % N;
`endif
      rem = req;
      rem[m_sel] = 1'b0;
      if (rem != '0) begin
        m_sel = ref_arb(rem, m_ptr);
      end else begin
        m_valid = 0;
        m_sel   = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then clock the model.
  // exp_sel >= 0 also demands that grant explicitly; -2 demands no grant.
  task automatic applyStimulus(input logic rst_v, input logic [N-1:0] req_v,
                               input logic ready_v, input int exp_sel);
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    rst_n = rst_v;
    req   = req_v;
    ready = ready_v;
    #1;
    if (model_known != 0) begin
      exp_gnt = '0;
      if (m_valid != 0) exp_gnt[m_sel] = 1'b1;
      checkOutput("valid", 32'(valid), 32'(m_valid));
      checkOutput("sel", 32'(sel), 32'(m_sel));
      checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
      checkOutput("ack", 32'(ack), ready ? 32'(exp_gnt) : 32'd0);
      if (exp_sel >= 0) begin
        checkOutput("dir_valid", 32'(valid), 32'd1);
        checkOutput("dir_sel", 32'(sel), 32'(exp_sel));
      end else if (exp_sel == -2) begin
        checkOutput("dir_idle", 32'({valid, gnt}), 32'd0);
      end
    end
    @(posedge clk);
    model_update();
  endtask

  int seq_tab [6];
  logic [N-1:0] cur_req;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;

    // Reset, then reset again in the middle of a grant.
    applyStimulus(1'b0, 4'b0000, 1'b0, -1);
    applyStimulus(1'b1, 4'b1111, 1'b0, -2);
    applyStimulus(1'b1, 4'b1111, 1'b1, 0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1);
    applyStimulus(1'b1, 4'b1111, 1'b1, -2);
    applyStimulus(1'b1, 4'b1111, 1'b0, 0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 0);

    // Single requester held off by backpressure for three cycles.
    applyStimulus(1'b1, 4'b0100, 1'b0, -2);
    applyStimulus(1'b1, 4'b0100, 1'b0, 2);
    applyStimulus(1'b1, 4'b0100, 1'b0, 2);
    applyStimulus(1'b1, 4'b0100, 1'b0, 2);
    applyStimulus(1'b1, 4'b0100, 1'b1, 2);
    applyStimulus(1'b1, 4'b0000, 1'b0, -2);

    // Wrap-around: pointer sits at 3 after serving 2.
    applyStimulus(1'b1, 4'b1001, 1'b0, -2);
    applyStimulus(1'b1, 4'b1001, 1'b1, 3);
    applyStimulus(1'b1, 4'b0001, 1'b1, 0);
    applyStimulus(1'b1, 4'b0000, 1'b0, -2);

    // Everyone requesting with ready held high: back-to-back grants.
`ifdef RR_ARBITER_PRIO0_EN
    seq_tab = '{0, 1, 0, 2, 0, 3};
`else
    seq_tab = '{0, 1, 2, 3, 0, 1};
`endif
    applyStimulus(1'b0, 4'b0000, 1'b0, -1);
    applyStimulus(1'b1, 4'b1111, 1'b1, -2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b1111, 1'b1, seq_tab[i]);
    end

    // Backpressure while a new request appears; next grant goes to 3.
    applyStimulus(1'b0, 4'b0000, 1'b0, -1);
    applyStimulus(1'b1, 4'b0010, 1'b0, -2);
    applyStimulus(1'b1, 4'b0010, 1'b0, 1);
    applyStimulus(1'b1, 4'b1010, 1'b0, 1);
    applyStimulus(1'b1, 4'b1010, 1'b0, 1);
    applyStimulus(1'b1, 4'b1010, 1'b1, 1);
    applyStimulus(1'b1, 4'b1000, 1'b0, 3);
    applyStimulus(1'b1, 4'b1000, 1'b1, 3);

    // Random sticky requesters: a bit stays up until its transfer edge.
    cur_req = '0;
    for (int c = 0; c < 400; c++) begin
      logic rst_v;
      logic rdy_v;
      if (last_served >= 0) cur_req[last_served] = 1'b0;
      cur_req = cur_req | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      rdy_v = ($urandom_range(0, 3) != 0);
      rst_v = ($urandom_range(0, 59) != 0);
      applyStimulus(rst_v, cur_req, rdy_v, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

- Round-robin arbiter that sits directly upstream of the team's `mux` block and drives its select input.
- Chooses one of `2**SEL_WIDTH` requesters and presents the winner's index on `sel`, so `mux` routes that requester's data.
- Holds the choice stable under a valid/ready handshake with the downstream consumer.
- Returns a one-cycle acknowledge to the served requester.

## Interface
- `SEL_WIDTH`, default 1: select width; number of requesters `N = 2**SEL_WIDTH`. Must be ≥1 and must equal the `SEL_WIDTH` of the `mux` it drives.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req` input N: per-requester request. Sticky: once high, stays high until that requester's `ack`.
- `ready` input 1: downstream accepts the current selection this cycle.
- `valid` output 1: a grant is active and `sel` is meaningful.
- `sel` output SEL_WIDTH: binary index of the granted requester; connects to `mux.sel`.
- `gnt` output N: one-hot grant. Equals `1 << sel` when `valid`, else 0.
- `ack` output N: one-hot transfer completion, equal to `gnt & {N{ready}}` (combinational from registered `gnt` and `ready`).

## Operation
- Internal state:
  - Round-robin pointer `ptr` (SEL_WIDTH bits).
  - Registered `valid`, `sel`, `gnt`.
  - Two-state FSM: IDLE (`valid`=0) and GRANT (`valid`=1).
- Arbitration function:
  - Inputs: a request vector `r` and `ptr`.
  - Result: the first index `i` with `r[i]`=1, scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1` (modulo N, wrap-around).
- IDLE:
  - If `|req`: winner = arb(`req`, `ptr`); next cycle `sel`=winner, `gnt`=one-hot(winner), `valid`=1, state → GRANT.
  - Otherwise remain IDLE, outputs 0.
- GRANT, `ready`=0:
  - Hold `sel`, `gnt` and `valid` unchanged.
  - `req` changes are ignored. Dropping `req[sel]` before `ack` is a protocol violation; the grant is still held.
- GRANT, `ready`=1 (transfer; `ack[sel]`=1 this cycle):
  - `ptr` ← (`sel`+1) mod N. From `sel`=N-1 this wraps to 0.
  - Let `r` = `req & ~gnt`. If `|r`: re-arbitrate in the same cycle with arb(`r`, (`sel`+1) mod N) and stay in GRANT with the new winner. This gives back-to-back grants with no bubble.
  - Otherwise → IDLE, with `valid`, `gnt` and `sel` all 0.
- `ptr` changes only on a transfer.
- Fairness: with all N requesters continuously asserting, each is granted exactly once per N transfers.
- Reset (`rst_n`=0 at a rising edge, including mid-grant):
  - `valid`=0, `sel`=0, `gnt`=0, `ptr`=0, state IDLE.
  - `ack`=0 from the first post-reset cycle.
  - Any in-flight grant is dropped without `ack`.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge k gives `valid`=1 after edge k.
- Transfer to next grant: 0 bubble cycles when other requests are pending; otherwise `valid` falls after the transfer edge.
- `ack` is asserted only during the transfer cycle itself (same cycle as `valid && ready`).
- `sel` and `gnt` are registered, so `mux` select timing is clean. `ack` has one AND level after the `gnt` flops.
- Re-arbitration path: one N-bit circular priority encoder plus the `ptr` increment, all in a single cycle.

## Configuration
- Macro `RR_ARBITER_PRIO0_EN`.
- Defined:
  - Requester 0 is high priority. At every arbitration point (IDLE, or re-arbitration on a transfer), if requester 0 is eligible it wins regardless of `ptr`.
  - A transfer to requester 0 does not update `ptr`.
  - Requesters 1..N-1 stay round-robin among themselves.
- Undefined: pure round-robin as above, with all requesters equal.

## Test plan
All scenarios use SEL_WIDTH=2 (N=4).
- Reset while `req`=4'b1111 and `valid`=1 → the next cycle has `valid`=0, `gnt`=0, `sel`=0, `ack`=0. The first grant after reset is index 0.
- Single requester: `req`=4'b0100 with `ready` held 0 for 3 cycles, then 1 → `valid` after 1 cycle, `sel`=2 held stable for 4 cycles, `ack`=4'b0100 in the `ready` cycle, then IDLE.
- `req`=4'b1111 and `ready`=1 held continuously → `sel` sequence 0,1,2,3,0,1 with no bubbles; one `ack` per cycle.
- Wrap-around: `ptr`=3 after serving index 2, `req`=4'b1001 → grant 3, then grant 0.
- Backpressure: `ready`=0 while `req` changes from 4'b0010 to 4'b1010 → `sel` stays 1 with no glitch until `ready`. The next grant is 3.
- With `RR_ARBITER_PRIO0_EN` defined, `req`=4'b1111, `ready`=1, requester 0 re-asserting `req[0]` the cycle after each of its `ack`s → sequence 0,1,0,2,0,3.
- Without the macro, the same stimulus → 0,1,2,3.
